lcrc_tx_sequencer: RTL
======================

// Module: lcrc_tx_sequencer
// PURPOSE
//  Data-link transmit sequencer. Takes TLP bytes from the transaction layer and frames each TLP.
//  Framing: prepends a 2-byte sequence header, runs the byte-serial LCRC engine, appends a 4-byte LCRC.
//  Sits between the TLP source and the replay buffer; the dll_* stream is what the replay buffer stores.
// PARAMETERS
//  MAX_BYTES  4096  max TLP payload bytes per frame (count of accepted tlp_data bytes)
//  SEQ_W      12    sequence number width
// PORTS
//  clk           in   1      clock; one clock
//  reset         in   1      reset is asynchronous and active-low
//  tlp_valid     in   1      source byte valid
//  tlp_data      in   8      source byte
//  tlp_last      in   1      marks final TLP byte
//  tlp_ready     out  1      sequencer accepts byte
//  dll_valid     out  1      framed byte valid
//  dll_data      out  8      framed byte
//  dll_sof       out  1      first byte of frame (sequence header high byte)
//  dll_eof       out  1      last byte of frame (LCRC byte 3)
//  dll_ready     in   1      replay buffer accepts byte
//  seq_load      in   1      load next sequence number (honoured in IDLE only)
//  seq_load_val  in   SEQ_W  value for seq_load
//  next_seq      out  SEQ_W  sequence number the next frame will carry
//  len_err       out  1      one-cycle pulse: payload hit MAX_BYTES without tlp_last
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, next_seq=0, crc=32'hFFFF_FFFF, byte_cnt=0, crc_idx=0, len_err=0.
//   Reset also forces dll_valid=0 and tlp_ready=0.
//  Transfer on a port = valid && ready at a rising clk edge. The sequencer never drops a byte.
//   It never changes dll_data while dll_valid && !dll_ready.
//  States:
//   IDLE: tlp_ready=0, dll_valid=0. tlp_valid=1 -> load crc=FFFF_FFFF, go to SEQ_HI. A seq_load in the same cycle wins first.
//   SEQ_HI: dll_valid=1, dll_data={4'b0,next_seq[11:8]}, dll_sof=1. On transfer, fold the byte into the CRC and go to SEQ_LO.
//   SEQ_LO: dll_data=next_seq[7:0]. On transfer, fold into CRC, clear byte_cnt, go to PAYLOAD.
//   PAYLOAD: pass-through, zero latency.
//    dll_valid=tlp_valid, dll_data=tlp_data, tlp_ready=dll_ready.
//    Each transfer folds into the CRC and increments byte_cnt.
//    Transfer with tlp_last=1 -> CRC, crc_idx=0.
//    Transfer with byte_cnt==MAX_BYTES-1 and tlp_last=0: the byte is treated as last, len_err pulses next cycle, go to CRC.
//     Following source bytes start a new frame.
//   CRC: tlp_ready=0, dll_valid=1, dll_data=~crc[8*crc_idx +: 8]; dll_eof=1 when crc_idx==3.
//    Transfer increments crc_idx. Transfer at crc_idx==3 -> IDLE and next_seq=next_seq+1 (wraps 4095->0).
//  CRC arithmetic: reflected CRC-32 (poly 32'h04C11DB7, shift-right form 32'hEDB88320), byte bits consumed LSB first.
//   CRC register is frozen outside transfers.
//  seq_load outside IDLE: ignored. dll_ready low in any state: state, crc and counters hold.
//  Reset mid-frame: frame abandoned, partial bytes already sent are not retracted.
//   next_seq returns to 0; the replay buffer is purged by the same reset.
// STRUCTURE
//  Shared dll package: sequencer state encoding, LCRC_POLY=32'h04C11DB7, LCRC_INIT=32'hFFFF_FFFF, SEQ_W, header nibble constant 4'b0.
//  Sub-module lcrc32_byte_step: combinational crc_next = f(crc_in[31:0], byte_in[7:0]).
//   One instance; its output is registered here.
// TESTING
//  1 lcrc32_byte_step unit: init FFFF_FFFF, fold ASCII "123456789", invert -> 32'hCBF43926.
//  2 One 4-byte TLP DE AD BE EF, next_seq=0, dll_ready=1. Required dll stream: 00 00 DE AD BE EF + 4 LCRC bytes.
//    LCRC bytes must match the bench model over 00 00 DE AD BE EF. sof on byte0, eof on byte9, next_seq -> 1.
//  3 Same TLP with dll_ready toggled 1010 pseudo-random: identical byte sequence.
//    No duplicate or lost bytes, tlp_ready never high while dll_ready low.
//  4 seq_load=1, seq_load_val=12'hFFF in IDLE, then two 1-byte TLPs.
//    Headers must be 0F FF then 00 00, and next_seq ends at 1.
//  5 MAX_BYTES=8 build, 10-byte TLP with tlp_last on byte 10: first frame ends after byte 8 with valid LCRC.
//    len_err pulses once. Bytes 9-10 form a second frame with seq+1.
//  6 Assert reset in PAYLOAD after 2 bytes: dll_valid=0 and tlp_ready=0 immediately, next_seq=0.
//    The next TLP is framed correctly from header.

Source files
------------

// File: rtl/lcrc_tx_sequencer_pkg.sv
// Shared data-link definitions for the LCRC transmit sequencer: state encoding,
// LCRC constants, sequence number width and the framing header nibble.
package lcrc_tx_sequencer_pkg;

    localparam int          SEQ_W          = 12;
    localparam logic [31:0] LCRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] LCRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [3:0]  SEQ_HDR_NIBBLE = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEQ_HI,
        ST_SEQ_LO,
        ST_PAYLOAD,
        ST_CRC
    } seq_state_e;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // The byte engine shifts right, so it needs the bit-reversed polynomial.
    localparam logic [31:0] LCRC_POLY_REFL = reflect32(LCRC_POLY);

endpackage

// File: rtl/lcrc_tx_sequencer_if.sv
// Byte-stream bundle between TLP source, sequencer and replay buffer.
// master = sequencer side, slave = source/replay-buffer side.
interface lcrc_tx_sequencer_if;

    logic       tlp_valid;
    logic [7:0] tlp_data;
    logic       tlp_last;
    logic       tlp_ready;

    logic       dll_valid;
    logic [7:0] dll_data;
    logic       dll_sof;
    logic       dll_eof;
    logic       dll_ready;

    modport master (
        input  tlp_valid, tlp_data, tlp_last, dll_ready,
        output tlp_ready, dll_valid, dll_data, dll_sof, dll_eof
    );

    modport slave (
        output tlp_valid, tlp_data, tlp_last, dll_ready,
        input  tlp_ready, dll_valid, dll_data, dll_sof, dll_eof
    );

endinterface

// File: rtl/lcrc_tx_sequencer_crc.sv
// Combinational reflected CRC-32 byte step: folds one byte, LSB first,
// into the running LCRC register.
module lcrc32_byte_step
    import lcrc_tx_sequencer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc_in ^ {24'h000000, byte_in};
        for (int i = 0; i < 8; i++) begin
            crc_next = {1'b0, crc_next[31:1]} ^ (crc_next[0] ? LCRC_POLY_REFL : 32'h0000_0000);
        end
    end

endmodule

// File: rtl/lcrc_tx_sequencer.sv
// Data-link transmit sequencer: frames each TLP as a 2-byte sequence header,
// the pass-through payload and a 4-byte inverted LCRC, for the replay buffer.
module lcrc_tx_sequencer
    import lcrc_tx_sequencer_pkg::*;
#(
    parameter int MAX_BYTES = 4096
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    lcrc_tx_sequencer_if.master  bus,
    input  logic                 seq_load,
    input  logic [SEQ_W-1:0]     seq_load_val,
    output logic [SEQ_W-1:0]     next_seq,
    output logic                 len_err,
    output logic                 busy
);

    localparam int              CNT_W    = $clog2(MAX_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BYTES - 1);

    seq_state_e       state_q, state_d;
    logic [SEQ_W-1:0] next_seq_q, next_seq_d;
    logic [31:0]      crc_q, crc_d, crc_step;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [1:0]       crc_idx_q, crc_idx_d;
    logic             len_err_q, len_err_d;
    logic             dll_xfer;

    // The byte folded in is always the one currently presented on dll_data.
    lcrc32_byte_step u_step (
        .crc_in   (crc_q),
        .byte_in  (bus.dll_data),
        .crc_next (crc_step)
    );

    always_comb begin
        bus.dll_valid = 1'b0;
        bus.dll_data  = 8'h00;
        bus.dll_sof   = 1'b0;
        bus.dll_eof   = 1'b0;
        bus.tlp_ready = 1'b0;
        unique case (state_q)
            ST_SEQ_HI: begin
                bus.dll_valid = 1'b1;
                bus.dll_data  = {SEQ_HDR_NIBBLE, next_seq_q[11:8]};
                bus.dll_sof   = 1'b1;
            end
            ST_SEQ_LO: begin
                bus.dll_valid = 1'b1;
                bus.dll_data  = next_seq_q[7:0];
            end
            ST_PAYLOAD: begin
                bus.dll_valid = bus.tlp_valid;
                bus.dll_data  = bus.tlp_data;
                bus.tlp_ready = bus.dll_ready;
            end
            ST_CRC: begin
                bus.dll_valid = 1'b1;
                bus.dll_data  = ~crc_q[{crc_idx_q, 3'b000} +: 8];
                bus.dll_eof   = (crc_idx_q == 2'd3);
            end
            default: ;
        endcase
    end

    assign dll_xfer = bus.dll_valid && bus.dll_ready;

    // Everything holds unless a dll transfer happens; IDLE only arms the next frame.
    always_comb begin
        state_d    = state_q;
        next_seq_d = next_seq_q;
        crc_d      = crc_q;
        byte_cnt_d = byte_cnt_q;
        crc_idx_d  = crc_idx_q;
        len_err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (seq_load) begin
                    next_seq_d = seq_load_val;
                end
                if (bus.tlp_valid) begin
                    crc_d   = LCRC_INIT;
                    state_d = ST_SEQ_HI;
                end
            end
            ST_SEQ_HI: begin
                if (dll_xfer) begin
                    crc_d   = crc_step;
                    state_d = ST_SEQ_LO;
                end
            end
            ST_SEQ_LO: begin
                if (dll_xfer) begin
                    crc_d      = crc_step;
                    byte_cnt_d = '0;
                    state_d    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (dll_xfer) begin
                    crc_d      = crc_step;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (bus.tlp_last) begin
                        crc_idx_d = 2'd0;
                        state_d   = ST_CRC;
                    end else if (byte_cnt_q == LAST_CNT) begin
                        // Oversized TLP: cut the frame here; the rest becomes a new frame.
                        crc_idx_d = 2'd0;
                        len_err_d = 1'b1;
                        state_d   = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (dll_xfer) begin
                    crc_idx_d = crc_idx_q + 2'd1;
                    if (crc_idx_q == 2'd3) begin
                        next_seq_d = next_seq_q + 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            next_seq_q <= '0;
            crc_q      <= LCRC_INIT;
            byte_cnt_q <= '0;
            crc_idx_q  <= 2'd0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_seq_q <= next_seq_d;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            crc_idx_q  <= crc_idx_d;
            len_err_q  <= len_err_d;
        end
    end

    assign next_seq = next_seq_q;
    assign len_err  = len_err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
